// File: rtl/sdram_port_sched_pkg.sv
// Shared encodings and defaults for the two-port SDRAM scheduler.
// Imported by the interface, the address generator and the scheduler top.
package sdram_sched_pkg;

  localparam int ADDR_W = 24;
  localparam logic [ADDR_W-1:0] FRAME_MIN_DEF = 24'd0;
  localparam logic [ADDR_W-1:0] FRAME_MAX_DEF = 24'd307200;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } state_e;

  typedef enum logic {
    G_W = 1'b0,
    G_R = 1'b1
  } grant_e;

  // Zero-extend a 10-bit burst length to a full word address.
  function automatic logic [ADDR_W-1:0] burst_ext(input logic [9:0] len);
    return {{(ADDR_W - 10){1'b0}}, len};
  endfunction

endpackage

// File: rtl/sdram_port_sched_if.sv
// Request/acknowledge bus between the port scheduler and the SDRAM controller.
// The scheduler is the master; the controller (or a bench model) is the slave.
interface sdram_port_sched_if;
  import sdram_sched_pkg::*;

  logic              sdram_wr_req;
  logic              sdram_rd_req;
  logic              sdram_wr_ack;
  logic              sdram_rd_ack;
  logic [ADDR_W-1:0] sdram_wr_addr;
  logic [ADDR_W-1:0] sdram_rd_addr;
  logic [9:0]        sdram_wr_burst;
  logic [9:0]        sdram_rd_burst;

  modport master (
    output sdram_wr_req, sdram_rd_req, sdram_wr_addr, sdram_rd_addr,
           sdram_wr_burst, sdram_rd_burst,
    input  sdram_wr_ack, sdram_rd_ack
  );

  modport slave (
    input  sdram_wr_req, sdram_rd_req, sdram_wr_addr, sdram_rd_addr,
           sdram_wr_burst, sdram_rd_burst,
    output sdram_wr_ack, sdram_rd_ack
  );

endinterface

// File: rtl/sdram_port_sched_addr_gen.sv
// Burst address generator for one frame buffer port: steps by a burst,
// wraps inside [FRAME_MIN, FRAME_MAX) and flips or follows the bank bit.
module sdram_addr_gen
  import sdram_sched_pkg::*;
#(
  parameter logic [9:0]        BURST     = 10'd512,
  parameter logic [ADDR_W-1:0] FRAME_MIN = FRAME_MIN_DEF,
  parameter logic [ADDR_W-1:0] FRAME_MAX = FRAME_MAX_DEF,
  parameter bit                PINGPONG  = 1'b1,
  parameter bit                BANK_RST  = 1'b0,
  parameter bit                FOLLOW    = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              step,
  input  logic              load,
  input  logic              follow_bank,
  output logic [ADDR_W-1:0] addr,
  output logic              wrap
);

  localparam logic [ADDR_W-2:0] OFF_MIN = FRAME_MIN[ADDR_W-2:0];

  logic [ADDR_W-2:0] off_r;
  logic              bank_r;
  logic              wrap_r;
  logic [ADDR_W-1:0] next_s;
  logic              wrap_s;
  logic              bank_flip_s;

  // Next burst address and wrap detection; a follower takes the opposite of the other port's bank.
  always_comb begin
    next_s      = {1'b0, off_r} + burst_ext(BURST);
    wrap_s      = step && (next_s == FRAME_MAX);
    bank_flip_s = FOLLOW ? ~follow_bank : ~bank_r;
  end

  // Offset, bank and wrap pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_r  <= OFF_MIN;
      bank_r <= BANK_RST;
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= wrap_s;
      if (load) begin
        off_r  <= OFF_MIN;
        bank_r <= BANK_RST;
      end else if (wrap_s) begin
        off_r  <= OFF_MIN;
        bank_r <= PINGPONG ? bank_flip_s : bank_r;
      end else if (step) begin
        off_r  <= next_s[ADDR_W-2:0];
      end else begin
        off_r  <= off_r;
      end
    end
  end

  assign addr = {bank_r, off_r};
  assign wrap = wrap_r;

endmodule

// File: rtl/sdram_port_sched.sv
// Round-robin scheduler between the camera write FIFO and display read FIFO;
// holds the SDRAM request until acknowledged and ping-pongs frame buffers.
module sdram_port_sched #(
  parameter int                ADDR_W        = sdram_sched_pkg::ADDR_W,
  parameter logic [9:0]        WR_BURST      = 10'd512,
  parameter logic [9:0]        RD_BURST      = 10'd512,
  parameter logic [ADDR_W-1:0] FRAME_MIN     = sdram_sched_pkg::FRAME_MIN_DEF,
  parameter logic [ADDR_W-1:0] FRAME_MAX     = sdram_sched_pkg::FRAME_MAX_DEF,
  parameter bit                PINGPONG      = 1'b1,
  parameter logic [10:0]       RD_FIFO_DEPTH = 11'd1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sdram_init_done,
  input  logic [10:0]               wr_fifo_used,
  input  logic [10:0]               rd_fifo_used,
  input  logic                      rd_enable,
  input  logic                      wr_load,
  input  logic                      rd_load,
  output logic                      wr_frame_done,
  output logic                      busy,
  sdram_port_sched_if.master        bus
);
  import sdram_sched_pkg::*;

  state_e      state_r, next_state_s;
  grant_e      last_grant_r, next_grant_s;
  logic        wr_req_r, rd_req_r, wr_req_nxt_s, rd_req_nxt_s;
  logic        wr_ack_d_r, rd_ack_d_r;
  logic        wr_pend_r, rd_pend_r;
  logic        busy_r;
  logic        w_elig_s, r_elig_s;
  logic        wr_step_s, rd_step_s;
  logic        wr_apply_s, rd_apply_s;
  logic [11:0] rd_space_s;
  logic [ADDR_W-1:0] wr_addr_s, rd_addr_s;
  logic        rd_wrap_unused_s;

  // Port eligibility; the read FIFO needs a whole burst of free space.
  always_comb begin
    rd_space_s = {1'b0, RD_FIFO_DEPTH} - {1'b0, rd_fifo_used};
    w_elig_s   = sdram_init_done && (wr_fifo_used >= {1'b0, WR_BURST});
    r_elig_s   = sdram_init_done && rd_enable && (rd_fifo_used <= RD_FIFO_DEPTH) &&
                 (rd_space_s >= {2'b00, RD_BURST});
    wr_apply_s = wr_pend_r && (state_r == S_IDLE);
    rd_apply_s = rd_pend_r && (state_r == S_IDLE);
  end

  // Arbitration and burst completion (ack falling edge).
  always_comb begin
    next_state_s = state_r;
    next_grant_s = last_grant_r;
    wr_req_nxt_s = wr_req_r;
    rd_req_nxt_s = rd_req_r;
    wr_step_s    = 1'b0;
    rd_step_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        wr_req_nxt_s = 1'b0;
        rd_req_nxt_s = 1'b0;
        if (w_elig_s && (!r_elig_s || (last_grant_r == G_R))) begin
          next_state_s = S_WR;
          wr_req_nxt_s = 1'b1;
        end else if (r_elig_s) begin
          next_state_s = S_RD;
          rd_req_nxt_s = 1'b1;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_WR: begin
        if (wr_ack_d_r && !bus.sdram_wr_ack) begin
          wr_req_nxt_s = 1'b0;
          wr_step_s    = 1'b1;
          next_grant_s = G_W;
          next_state_s = S_IDLE;
        end else if (bus.sdram_wr_ack) begin
          wr_req_nxt_s = 1'b0;
        end else begin
          wr_req_nxt_s = wr_req_r;
        end
      end
      S_RD: begin
        if (rd_ack_d_r && !bus.sdram_rd_ack) begin
          rd_req_nxt_s = 1'b0;
          rd_step_s    = 1'b1;
          next_grant_s = G_R;
          next_state_s = S_IDLE;
        end else if (bus.sdram_rd_ack) begin
          rd_req_nxt_s = 1'b0;
        end else begin
          rd_req_nxt_s = rd_req_r;
        end
      end
      default: begin
        next_state_s = S_IDLE;
        wr_req_nxt_s = 1'b0;
        rd_req_nxt_s = 1'b0;
      end
    endcase
  end

  // State, request, ack history and pending-load registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= S_IDLE;
      last_grant_r <= G_R;
      wr_req_r     <= 1'b0;
      rd_req_r     <= 1'b0;
      wr_ack_d_r   <= 1'b0;
      rd_ack_d_r   <= 1'b0;
      wr_pend_r    <= 1'b0;
      rd_pend_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      last_grant_r <= next_grant_s;
      wr_req_r     <= wr_req_nxt_s;
      rd_req_r     <= rd_req_nxt_s;
      wr_ack_d_r   <= bus.sdram_wr_ack;
      rd_ack_d_r   <= bus.sdram_rd_ack;
      wr_pend_r    <= wr_load || (wr_pend_r && !wr_apply_s);
      rd_pend_r    <= rd_load || (rd_pend_r && !rd_apply_s);
      busy_r       <= (next_state_s != S_IDLE);
    end
  end

  sdram_addr_gen #(
    .BURST(WR_BURST), .FRAME_MIN(FRAME_MIN), .FRAME_MAX(FRAME_MAX),
    .PINGPONG(PINGPONG), .BANK_RST(1'b0), .FOLLOW(1'b0)
  ) u_wr_gen (
    .clk(clk), .rst_n(rst_n), .step(wr_step_s), .load(wr_apply_s),
    .follow_bank(1'b0), .addr(wr_addr_s), .wrap(wr_frame_done)
  );

  // The reader jumps to the frame just finished by the writer.
  sdram_addr_gen #(
    .BURST(RD_BURST), .FRAME_MIN(FRAME_MIN), .FRAME_MAX(FRAME_MAX),
    .PINGPONG(PINGPONG), .BANK_RST(PINGPONG), .FOLLOW(1'b1)
  ) u_rd_gen (
    .clk(clk), .rst_n(rst_n), .step(rd_step_s), .load(rd_apply_s),
    .follow_bank(wr_addr_s[ADDR_W-1]), .addr(rd_addr_s), .wrap(rd_wrap_unused_s)
  );

  assign bus.sdram_wr_req   = wr_req_r;
  assign bus.sdram_rd_req   = rd_req_r;
  assign bus.sdram_wr_addr  = wr_addr_s;
  assign bus.sdram_rd_addr  = rd_addr_s;
  assign bus.sdram_wr_burst = WR_BURST;
  assign bus.sdram_rd_burst = RD_BURST;
  assign busy               = busy_r;

endmodule

// File: tb/tb_sdram_port_sched.sv
// Scoreboard bench for sdram_port_sched: a controller model acks each request,
// and a reference address model predicts grant order, addresses and frame wraps.
module tb_sdram_port_sched;
  import sdram_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done = 1'b0;
  logic [10:0] wr_used = 11'd0;
  logic [10:0] rd_used = 11'd0;
  logic        rd_en = 1'b0;
  logic        wr_load = 1'b0;
  logic        rd_load = 1'b0;
  logic        wr_frame_done;
  logic        busy;

  sdram_port_sched_if bus();

  sdram_port_sched dut (
    .clk(clk), .rst_n(rst_n), .sdram_init_done(init_done),
    .wr_fifo_used(wr_used), .rd_fifo_used(rd_used), .rd_enable(rd_en),
    .wr_load(wr_load), .rd_load(rd_load),
    .wr_frame_done(wr_frame_done), .busy(busy), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [23:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   overlap_cnt = 0;
  int   rd_seen = 0;
  int   fd_cnt = 0;
  int   m_wr_off, m_rd_off;
  logic m_wr_bank, m_rd_bank;
  bit   prev_done;

  always @(negedge clk) begin
    if (bus.sdram_wr_req && bus.sdram_rd_req) overlap_cnt++;
    if (bus.sdram_rd_req) rd_seen++;
    if (wr_frame_done) fd_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_wr_off  = 0;
    m_rd_off  = 0;
    m_wr_bank = 1'b0;
    m_rd_bank = 1'b1;
    prev_done = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic [23:0] model_addr(input bit wr);
    logic [22:0] off;
    off = wr ? 23'(m_wr_off) : 23'(m_rd_off);
    return wr ? {m_wr_bank, off} : {m_rd_bank, off};
  endfunction

  task automatic model_step(input bit wr);
    if (wr) begin
      m_wr_off += 512;
      if (m_wr_off == 307200) begin
        m_wr_off  = 0;
        m_wr_bank = ~m_wr_bank;
      end
    end else begin
      m_rd_off += 512;
      if (m_rd_off == 307200) begin
        m_rd_off  = 0;
        m_rd_bank = ~m_wr_bank;
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.sdram_wr_ack = 1'b0;
    bus.sdram_rd_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // One granted burst: expect the predicted port/address, ack it, check req release.
  task automatic do_burst(input bit wr, input int ack_len, input bit pulse_load);
    exp_t e, got;
    int   n;
    bit   seen;
    e.wr   = wr;
    e.addr = model_addr(wr);
    exp_q.push_back(e);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      if (bus.sdram_wr_req || bus.sdram_rd_req) seen = 1'b1;
      else n++;
    end
    if (prev_done) begin
      checks++;
      if (seen && n == 0) $display("FAIL idle_gap: req high %0d cycles after completion, required >= 1", n);
      if (seen && n == 0) errors++;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL req_timeout: no request within 40 cycles, expected wr=%0d addr=%h", e.wr, e.addr);
      void'(exp_q.pop_front());
      return;
    end
    got.wr   = bus.sdram_wr_req;
    got.addr = bus.sdram_wr_req ? bus.sdram_wr_addr : bus.sdram_rd_addr;
    e = exp_q.pop_front();
    if (got !== e) begin
      errors++;
      $display("FAIL grant: got wr=%0d addr=%h, expected wr=%0d addr=%h", got.wr, got.addr, e.wr, e.addr);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy: got %0b during burst, expected 1", busy);
    end
    if (pulse_load) wr_load = 1'b1;
    @(negedge clk);
    wr_load = 1'b0;
    @(negedge clk);
    if (got.wr) bus.sdram_wr_ack = 1'b1;
    else bus.sdram_rd_ack = 1'b1;
    repeat (ack_len) @(negedge clk);
    bus.sdram_wr_ack = 1'b0;
    bus.sdram_rd_ack = 1'b0;
    checks++;
    if ((got.wr ? bus.sdram_wr_req : bus.sdram_rd_req) !== 1'b0) begin
      errors++;
      $display("FAIL req_drop: req still high after ack, expected 0");
    end
    model_step(wr);
    prev_done = 1'b1;
  endtask

  task automatic test_reset();
    int reqs;
    init_done = 1'b1;
    wr_used   = 11'd600;
    apply_reset();
    checks++;
    if ({bus.sdram_wr_req, bus.sdram_rd_req, wr_frame_done, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got req_w/req_r/fd/busy=%b, expected 0000",
               {bus.sdram_wr_req, bus.sdram_rd_req, wr_frame_done, busy});
    end
    checks++;
    if (bus.sdram_wr_addr !== 24'h000000 || bus.sdram_rd_addr !== 24'h800000) begin
      errors++;
      $display("FAIL reset_addr: got wr=%h rd=%h, expected 000000 800000", bus.sdram_wr_addr, bus.sdram_rd_addr);
    end
    checks++;
    if (bus.sdram_wr_burst !== 10'd512 || bus.sdram_rd_burst !== 10'd512) begin
      errors++;
      $display("FAIL burst_len: got wr=%0d rd=%0d, expected 512 512", bus.sdram_wr_burst, bus.sdram_rd_burst);
    end
    init_done = 1'b0;
    rd_en     = 1'b1;
    apply_reset();
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.sdram_wr_req || bus.sdram_rd_req) reqs++;
    end
    checks++;
    if (reqs != 0) begin
      errors++;
      $display("FAIL no_init: got %0d request cycles before init_done, expected 0", reqs);
    end
  endtask

  task automatic test_write_only();
    int base;
    rd_en     = 1'b0;
    wr_used   = 11'd600;
    init_done = 1'b1;
    apply_reset();
    base = rd_seen;
    for (int i = 0; i < 3; i++) do_burst(1'b1, 1, 1'b0);
    checks++;
    if (rd_seen != base) begin
      errors++;
      $display("FAIL write_only_rd: got %0d read request cycles, expected 0", rd_seen - base);
    end
  endtask

  task automatic test_contention();
    int base;
    wr_used = 11'd600;
    rd_en   = 1'b1;
    rd_used = 11'd0;
    apply_reset();
    base = overlap_cnt;
    do_burst(1'b1, 1, 1'b0);
    do_burst(1'b0, 4, 1'b0);
    do_burst(1'b1, 1, 1'b0);
    do_burst(1'b0, 4, 1'b0);
    checks++;
    if (overlap_cnt != base) begin
      errors++;
      $display("FAIL req_overlap: got %0d cycles with both reqs, expected 0", overlap_cnt - base);
    end
    rd_en = 1'b0;
  endtask

  task automatic test_frame_wrap();
    int f0;
    wr_used = 11'd600;
    rd_en   = 1'b0;
    apply_reset();
    f0 = fd_cnt;
    for (int i = 1; i <= 601; i++) begin
      if (i == 600) begin
        checks++;
        if (fd_cnt != f0) begin
          errors++;
          $display("FAIL frame_done_early: got %0d pulses before burst 600, expected 0", fd_cnt - f0);
        end
      end
      do_burst(1'b1, 1, 1'b0);
      if (i == 600) begin
        checks++;
        if (bus.sdram_wr_addr !== 24'h04AE00) begin
          errors++;
          $display("FAIL last_burst_addr: got %h, expected 04ae00", bus.sdram_wr_addr);
        end
      end
    end
    checks++;
    if (fd_cnt != f0 + 1) begin
      errors++;
      $display("FAIL frame_done_count: got %0d pulses, expected 1", fd_cnt - f0);
    end
    wr_used = 11'd0;
  endtask

  task automatic test_read_follow();
    prev_done = 1'b0;
    rd_en     = 1'b1;
    rd_used   = 11'd0;
    for (int i = 1; i <= 601; i++) do_burst(1'b0, 2, 1'b0);
    rd_en = 1'b0;
  endtask

  task automatic test_load();
    wr_used = 11'd600;
    rd_en   = 1'b0;
    apply_reset();
    for (int i = 0; i < 4; i++) do_burst(1'b1, 1, 1'b0);
    do_burst(1'b1, 1, 1'b1);
    @(negedge clk);
    checks++;
    if (bus.sdram_wr_addr !== model_addr(1'b1)) begin
      errors++;
      $display("FAIL load_advance: got %h, expected %h", bus.sdram_wr_addr, model_addr(1'b1));
    end
    m_wr_off  = 0;
    m_wr_bank = 1'b0;
    prev_done = 1'b0;
    do_burst(1'b1, 1, 1'b0);
    wr_used = 11'd0;
  endtask

  task automatic test_reset_mid_read();
    int  reqs;
    bit  seen;
    rd_en     = 1'b1;
    rd_used   = 11'd0;
    init_done = 1'b1;
    seen      = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus.sdram_rd_req) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_read_req: no read request within 20 cycles, expected one");
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.sdram_rd_req, busy} !== 2'b00) begin
      errors++;
      $display("FAIL async_reset_req: got rd_req/busy=%b, expected 00", {bus.sdram_rd_req, busy});
    end
    checks++;
    if (bus.sdram_wr_addr !== 24'h000000 || bus.sdram_rd_addr !== 24'h800000) begin
      errors++;
      $display("FAIL async_reset_addr: got wr=%h rd=%h, expected 000000 800000", bus.sdram_wr_addr, bus.sdram_rd_addr);
    end
    init_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.sdram_wr_req || bus.sdram_rd_req) reqs++;
    end
    checks++;
    if (reqs != 0) begin
      errors++;
      $display("FAIL post_reset_idle: got %0d request cycles, expected 0", reqs);
    end
    init_done = 1'b1;
    do_burst(1'b0, 2, 1'b0);
    rd_en = 1'b0;
  endtask

  initial begin
    bus.sdram_wr_ack = 1'b0;
    bus.sdram_rd_ack = 1'b0;
    model_reset();
    test_reset();
    test_write_only();
    test_contention();
    test_frame_wrap();
    test_read_follow();
    test_load();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_port_sched.md
Name: sdram_port_sched

Overview:
- Two-port scheduler in front of the SDRAM controller (init/work state machines, req/ack interface).
- Port W is the camera write FIFO. Port R is the display read FIFO.
- Decides which port gets the SDRAM next and holds sdram_wr_req/sdram_rd_req until acknowledged.
- Generates burst addresses and burst lengths, wraps frame address ranges, and ping-pongs between two frame buffers (bank bit 23) so display never reads the frame being written.

Parameters:
- ADDR_W, 24, SDRAM word address width (bank 2 + row 13 + col 9).
- WR_BURST, 10'd512, words per write burst.
- RD_BURST, 10'd512, words per read burst.
- FRAME_MIN, 24'd0, first word address of a frame (bit 23 excluded).
- FRAME_MAX, 24'd307200, one past the last word of a frame; (FRAME_MAX-FRAME_MIN) is a multiple of both bursts.
- PINGPONG, 1, 1 = alternate bit 23 per frame; 0 = single buffer.
- RD_FIFO_DEPTH, 11'd1024, read FIFO depth in words.

Ports:
- clk  in  1  system clock, same as SDRAM controller.
- rst_n  in  1  async reset, active-low.
- sdram_init_done  in  1  controller initialisation complete.
- wr_fifo_used  in  11  words held in write FIFO.
- rd_fifo_used  in  11  words held in read FIFO.
- rd_enable  in  1  display active; read traffic allowed.
- wr_load  in  1  restart write frame pointer.
- rd_load  in  1  restart read frame pointer.
- sdram_wr_ack  in  1  controller write acknowledge.
- sdram_rd_ack  in  1  controller read acknowledge (high across the data phase).
- sdram_wr_req  out  1  write request to controller.
- sdram_rd_req  out  1  read request to controller.
- sdram_wr_addr  out  24  current write burst start address.
- sdram_rd_addr  out  24  current read burst start address.
- sdram_wr_burst  out  10  constant WR_BURST.
- sdram_rd_burst  out  10  constant RD_BURST.
- wr_frame_done  out  1  one-cycle pulse when the last burst of a frame completes.
- busy  out  1  scheduler not in S_IDLE.

Behaviour:
- Reset values:
  - req outputs 0.
  - wr_addr and rd_addr = FRAME_MIN, wr_bank = 0, rd_bank = 1 if PINGPONG else 0.
  - last_grant = R, so W wins the first tie.
  - wr_frame_done 0, busy 0.
  - States S_IDLE, S_WR, S_RD, encoded in the shared package; reset to S_IDLE.
- Eligibility:
  - W eligible when wr_fifo_used >= WR_BURST.
  - R eligible when rd_enable and (RD_FIFO_DEPTH - rd_fifo_used) >= RD_BURST.
  - Nothing is eligible while sdram_init_done = 0.
- S_IDLE:
  - If only one port is eligible, grant it.
  - If both are eligible, grant the port not in last_grant (round-robin).
  - Registered: the req output goes high the cycle after the decision, and the state moves to S_WR/S_RD.
- S_WR / S_RD:
  - Req is held high until ack is sampled high, then deasserts on the next edge.
  - The burst is complete on the ack falling edge (ack_d = 1, ack = 0). A single-cycle sdram_wr_ack completes one cycle after it rises.
  - On completion: advance the address by the burst length, update last_grant, return to S_IDLE.
  - At least one idle cycle is required between grants.
- Address wrap:
  - When addr + burst == FRAME_MAX, the address returns to FRAME_MIN.
  - Write wrap: pulse wr_frame_done; if PINGPONG, toggle wr_bank.
  - Read wrap: if PINGPONG, rd_bank <= ~wr_bank (the most recently completed frame); this sample is taken at the wrap cycle.
  - Output address = {bank, addr[22:0]}.
- Load requests:
  - wr_load and rd_load are latched into pending flags at any time.
  - Pending flags are applied only in S_IDLE, before arbitration, in that same cycle: address reset to FRAME_MIN, banks reset to their reset values, flag cleared.
  - A burst in flight is never truncated.
- Simultaneous events:
  - A load arriving in the same cycle as a burst completion is applied at the next S_IDLE cycle, after the address advance.
  - Ack rising while req is already low is ignored outside S_WR/S_RD.
- Async reset mid-burst returns every output to its reset value immediately. The controller's own reset covers its side.
- sdram_wr_burst and sdram_rd_burst are driven constantly from the parameters.

Decomposition:
- Package sdram_sched_pkg holds:
  - state encodings S_IDLE/S_WR/S_RD;
  - grant encodings G_W/G_R;
  - FRAME_MIN/FRAME_MAX defaults and ADDR_W.
- One natural sub-module: sdram_addr_gen, instantiated twice (write and read). Each instance provides step, wrap, load, bank toggle and a wrap pulse.

Test Plan:
- Write only: wr_fifo_used held at 600, sdram_init_done = 1, ack pulse two cycles after req → wr_addr 0, 512, 1024 on consecutive bursts; no rd_req ever.
- Contention: wr_fifo_used = 600, rd_enable = 1, rd_fifo_used = 0 → grant order W, R, W, R; no cycle with both reqs high.
- Frame wrap with PINGPONG = 1: run 600 write bursts → wr_frame_done pulses exactly once at burst 600; sdram_wr_addr jumps 0x04AE00 → 0x800000.
- Read bank follow: after the first write frame completes, run 600 read bursts → at read wrap rd_bank = 0 (opposite wr_bank = 1); sdram_rd_addr returns to 0x000000.
- wr_load asserted mid-S_WR at addr 2048 → burst finishes, address advances to 2560, then resets to FRAME_MIN in the following S_IDLE cycle; next burst at 0.
- rst_n pulled low while sdram_rd_req is high → req drops asynchronously; after release: addresses = FRAME_MIN, rd_bank = 1, no req until sdram_init_done and eligibility hold.
